rkv_vr_skid_stage: RTL and testbench
====================================

// Module: rkv_vr_skid_stage
// PURPOSE
//  Registered valid/ready pipeline stage with a 2-entry skid buffer.
//  Sits directly upstream of the protocol-checker interface's bus:
//  - s_* side: accepts from the producer.
//  - m_* side: drives the consumer whose handshake the interface asserts/assumes.
//  Breaks the combinational ready path, gives full throughput, and exposes a
//  consecutive-stall counter for debug.
// PARAMETERS
//  DATA_W       32  payload width in bits
//  STALL_CNT_W   8  width of the saturating stall counter
// PORTS
//  clk        in   1            clock, all logic rising-edge
//  rstn       in   1            asynchronous active-low reset
//  s_valid    in   1            upstream payload valid
//  s_data     in   DATA_W       upstream payload
//  s_ready    out  1            stage can accept
//  m_valid    out  1            downstream payload valid
//  m_data     out  DATA_W       downstream payload
//  m_ready    in   1            downstream accepts
//  stall_cnt  out  STALL_CNT_W  consecutive cycles with m_valid & !m_ready
//  proto_err  out  1            sticky upstream protocol violation flag
// BEHAVIOUR
//  Clock/reset: one clock (clk). rstn is asynchronous, active-low.
//  Reset values:
//  - state = EMPTY, s_ready = 1, m_valid = 0, m_data = 0, stall_cnt = 0, proto_err = 0.
//  - Main and skid registers clear to 0.
//  Transfers: s-transfer = s_valid & s_ready; m-transfer = m_valid & m_ready.
//  States (2-bit register):
//  - EMPTY: s_valid           -> BUSY,  main <= s_data
//  - BUSY:  s_valid & m_ready  -> BUSY,  main <= s_data
//           s_valid & !m_ready -> FULL,  skid <= s_data
//           !s_valid & m_ready -> EMPTY
//           otherwise hold
//  - FULL:  m_ready            -> BUSY,  main <= skid
//           otherwise hold
//  Outputs:
//  - m_valid = (state != EMPTY); m_data = main register.
//  - s_ready = (state != FULL), decoded from flops only; no combinational path from m_ready.
//  Latency and throughput:
//  - 1 cycle s-transfer to m_valid when empty; 1 transfer/cycle sustained.
//  - In FULL, s_valid is ignored (s_ready = 0); no data is lost or duplicated.
//  - Order is strictly FIFO; payload bits pass unmodified.
//  stall_cnt:
//  - +1 each cycle m_valid & !m_ready; saturates at 2**STALL_CNT_W-1.
//  - Clears to 0 on the cycle after any m-transfer, or whenever m_valid = 0.
//  Reset mid-operation: both entries discarded, state EMPTY immediately
//  (asynchronous); outputs take their reset values before the next edge.
// CONFIGURATION
//  RKV_SKID_PROTO_CHK_EN defined:
//  - proto_err sets (sticky until reset) when, in cycle N, s_valid & !s_ready,
//    and in cycle N+1 either !s_valid or s_data differs from cycle N.
//  - Payload is still accepted normally; the flag is the only effect.
//  RKV_SKID_PROTO_CHK_EN undefined:
//  - Checker logic is not compiled; proto_err is tied 0; the port list is unchanged.
// TESTING
//  1 Reset, s_valid=1 data 0xA5 for 1 cycle, m_ready=1
//    -> m_valid=1, m_data=0xA5 next cycle; EMPTY after.
//  2 Stream 0x1..0x8 back-to-back, m_ready=1
//    -> 8 outputs in order on 8 consecutive cycles, s_ready stays 1.
//  3 m_ready=0, push 0x11,0x22
//    -> s_ready=0 after 2nd accept; m_data=0x11; raise m_ready -> 0x11 then 0x22, s_ready=1.
//  4 Hold m_ready=0 300 cycles with m_valid=1, STALL_CNT_W=8
//    -> stall_cnt saturates at 255; 0 the cycle after the m-transfer.
//  5 FULL with 2 entries, drop rstn mid-cycle
//    -> m_valid=0, s_ready=1, stall_cnt=0 immediately; no stale data after release.
//  6 Macro on: stall upstream, change s_data 0x33->0x44 while s_ready=0
//    -> proto_err=1 next cycle, stays 1; macro off: proto_err always 0.

Source files
------------

// File: rtl/rkv_vr_skid_stage.sv
// rkv_vr_skid_stage: registered valid/ready stage with a 2-entry skid buffer.
// s_* side faces the producer, m_* side faces the consumer. s_ready comes only
// from the state flops, so the consumer's m_ready never reaches the producer
// combinationally. Full throughput is kept.
// stall_cnt counts consecutive cycles in which the consumer stalls the stage.
// Optional feature macro: RKV_SKID_PROTO_CHK_EN enables the sticky upstream
// protocol checker behind proto_err. When it is not defined, proto_err is 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | no entry held, m_valid = 0, s_ready = 1
// BUSY  | main holds the head entry, skid unused, s_ready = 1
// FULL  | main holds the head, skid holds the second entry, s_ready = 0

module rkv_vr_skid_stage #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_ready,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   proto_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       main_q, main_d;
  logic [DATA_W-1:0]       skid_q, skid_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // Output decode comes only from flops, so async reset shows up immediately.
  assign m_valid   = (state_q != EMPTY);
  assign s_ready   = (state_q != FULL);
  assign m_data    = main_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state and payload steering for the two-entry buffer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_valid) begin
          state_d = BUSY;
          main_d  = s_data;
        end
      end
      BUSY: begin
        if (s_valid && m_ready) begin
          main_d = s_data;
        end else if (s_valid && !m_ready) begin
          state_d = FULL;
          skid_d  = s_data;
        end else if (!s_valid && m_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so the producer's payload cannot be taken.
        if (m_ready) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Saturating count of consecutive downstream stalls. The count goes back to 0
  // after any m-transfer, and it stays 0 while nothing is presented.
  always_comb begin
    stall_cnt_d = '0;
    if (m_valid && !m_ready) begin
      if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // State, payload and stall-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef RKV_SKID_PROTO_CHK_EN
  logic              stalled_q;
  logic [DATA_W-1:0] stalled_data_q;
  logic              proto_err_q, proto_err_d;

  // The producer breaks the protocol if it offers a payload that is refused
  // and then, in the next cycle, withdraws it or changes it.
  always_comb begin
    proto_err_d = proto_err_q;
    if (stalled_q && (!s_valid || (s_data != stalled_data_q))) begin
      proto_err_d = 1'b1;
    end
  end

  // Remembers last cycle's refused offer. The error flag stays set until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stalled_q      <= 1'b0;
      stalled_data_q <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      stalled_q      <= s_valid && !s_ready;
      stalled_data_q <= s_data;
      proto_err_q    <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_rkv_vr_skid_stage.sv
// Directed bench for rkv_vr_skid_stage. The expected values are worked out by hand.
// If the bench is built with RKV_SKID_PROTO_CHK_EN defined, it expects proto_err to be set.
module tb_rkv_vr_skid_stage;

  localparam int DATA_W      = 32;
  localparam int STALL_CNT_W = 8;

`ifdef RKV_SKID_PROTO_CHK_EN
  localparam logic PROTO_EXP = 1'b1;
`else
  localparam logic PROTO_EXP = 1'b0;
`endif

  logic                   clk;
  logic                   rstn;
  logic                   s_valid;
  logic [DATA_W-1:0]      s_data;
  logic                   s_ready;
  logic                   m_valid;
  logic [DATA_W-1:0]      m_data;
  logic                   m_ready;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   proto_err;

  int checks;
  int failures;

  rkv_vr_skid_stage #(
    .DATA_W      (DATA_W),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .stall_cnt (stall_cnt),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    #12;
    check_val("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_val("rst_s_ready", {31'b0, s_ready}, 32'd1);
    check_val("rst_m_data", m_data, 32'd0);
    check_val("rst_stall", {24'b0, stall_cnt}, 32'd0);
    check_val("rst_proto", {31'b0, proto_err}, 32'd0);
    step();
    rstn = 1'b1;
    step();

    // 1: a single beat, consumer ready
    s_valid = 1'b1; s_data = 32'hA5; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    check_val("t1_m_valid", {31'b0, m_valid}, 32'd1);
    check_val("t1_m_data", m_data, 32'hA5);
    step();
    check_val("t1_empty", {31'b0, m_valid}, 32'd0);
    check_val("t1_s_ready", {31'b0, s_ready}, 32'd1);

    // 2: back-to-back stream, consumer ready
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = i;
      step();
      check_val("t2_m_valid", {31'b0, m_valid}, 32'd1);
      check_val("t2_m_data", m_data, i);
      check_val("t2_s_ready", {31'b0, s_ready}, 32'd1);
    end
    s_valid = 1'b0;
    step();
    check_val("t2_drain", {31'b0, m_valid}, 32'd0);

    // 3: consumer stalls, then two entries drain in order
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h11;
    step();
    check_val("t3_s_ready_busy", {31'b0, s_ready}, 32'd1);
    check_val("t3_head_11", m_data, 32'h11);
    s_data = 32'h22;
    step();
    s_valid = 1'b0;
    check_val("t3_s_ready_full", {31'b0, s_ready}, 32'd0);
    check_val("t3_hold_11", m_data, 32'h11);
    check_val("t3_stall_1", {24'b0, stall_cnt}, 32'd1);
    m_ready = 1'b1;
    step();
    check_val("t3_next_22", m_data, 32'h22);
    check_val("t3_s_ready_back", {31'b0, s_ready}, 32'd1);
    check_val("t3_stall_clr", {24'b0, stall_cnt}, 32'd0);
    step();
    check_val("t3_empty", {31'b0, m_valid}, 32'd0);

    // 4: long stall saturates the counter
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h5A;
    step();
    s_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) check_val("t4_stall_254", {24'b0, stall_cnt}, 32'd254);
      if (i == 255) check_val("t4_stall_255", {24'b0, stall_cnt}, 32'd255);
    end
    check_val("t4_stall_sat", {24'b0, stall_cnt}, 32'd255);
    check_val("t4_hold_5a", m_data, 32'h5A);
    m_ready = 1'b1;
    step();
    check_val("t4_stall_clr", {24'b0, stall_cnt}, 32'd0);
    check_val("t4_empty", {31'b0, m_valid}, 32'd0);

    // 5: async reset while the stage is full
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h77;
    step();
    s_data = 32'h88;
    step();
    s_valid = 1'b0;
    step();
    check_val("t5_full", {31'b0, s_ready}, 32'd0);
    check_val("t5_stall_2", {24'b0, stall_cnt}, 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check_val("t5_rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_val("t5_rst_s_ready", {31'b0, s_ready}, 32'd1);
    check_val("t5_rst_stall", {24'b0, stall_cnt}, 32'd0);
    check_val("t5_rst_m_data", m_data, 32'd0);
    step();
    rstn = 1'b1;
    m_ready = 1'b1;
    step();
    step();
    check_val("t5_no_stale", {31'b0, m_valid}, 32'd0);
    s_valid = 1'b1; s_data = 32'h99;
    step();
    s_valid = 1'b0;
    check_val("t5_fresh_data", m_data, 32'h99);
    step();
    check_val("t5_fresh_empty", {31'b0, m_valid}, 32'd0);

    // 6: producer changes payload while refused
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h30;
    step();
    s_data = 32'h31;
    step();
    s_data = 32'h33;
    step();
    check_val("t6_proto_pre", {31'b0, proto_err}, 32'd0);
    s_data = 32'h44;
    step();
    check_val("t6_proto_set", {31'b0, proto_err}, {31'b0, PROTO_EXP});
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    check_val("t6_drain_31", m_data, 32'h31);
    step();
    step();
    check_val("t6_proto_sticky", {31'b0, proto_err}, {31'b0, PROTO_EXP});
    check_val("t6_empty", {31'b0, m_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
